// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: default bus widths and
// FSM state encoding.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_WAIT_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ISSUE     = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd3;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester and controller-side signal bundle for sdram_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sdram_port_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              i_p0_req;
    logic              i_p0_rwn;
    logic [ADDR_W-1:0] i_p0_addr;
    logic [DATA_W-1:0] i_p0_wdata;
    logic              o_p0_ack;
    logic [DATA_W-1:0] o_p0_rdata;
    logic              o_p0_err;

    logic              i_p1_req;
    logic              i_p1_rwn;
    logic [ADDR_W-1:0] i_p1_addr;
    logic [DATA_W-1:0] i_p1_wdata;
    logic              o_p1_ack;
    logic [DATA_W-1:0] o_p1_rdata;
    logic              o_p1_err;

    logic              i_ctrl_init_done;
    logic              i_ctrl_busy;
    logic              i_ctrl_ack;
    logic [DATA_W-1:0] i_ctrl_rdata;
    logic              o_ctrl_advn;
    logic              o_ctrl_rwn;
    logic [ADDR_W-1:0] o_ctrl_addr;
    logic [DATA_W-1:0] o_ctrl_wdata;
    logic              o_busy;

    modport slave (
        input  i_p0_req, i_p0_rwn, i_p0_addr, i_p0_wdata,
        output o_p0_ack, o_p0_rdata, o_p0_err,
        input  i_p1_req, i_p1_rwn, i_p1_addr, i_p1_wdata,
        output o_p1_ack, o_p1_rdata, o_p1_err,
        input  i_ctrl_init_done, i_ctrl_busy, i_ctrl_ack, i_ctrl_rdata,
        output o_ctrl_advn, o_ctrl_rwn, o_ctrl_addr, o_ctrl_wdata, o_busy
    );

    modport master (
        output i_p0_req, i_p0_rwn, i_p0_addr, i_p0_wdata,
        input  o_p0_ack, o_p0_rdata, o_p0_err,
        output i_p1_req, i_p1_rwn, i_p1_addr, i_p1_wdata,
        input  o_p1_ack, o_p1_rdata, o_p1_err,
        output i_ctrl_init_done, i_ctrl_busy, i_ctrl_ack, i_ctrl_rdata,
        input  o_ctrl_advn, o_ctrl_rwn, o_ctrl_addr, o_ctrl_wdata, o_busy
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. With both ports requesting the
// port that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_grant
);
    // Select the winning port from the request vector and the previous winner
    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        case (i_req)
            2'b01:   o_grant = 1'b0;
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_last_grant;
            default: o_grant = 1'b0;
        endcase
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the SDRAM controller.
// Serialises single-word transactions, issues the active-low advance strobe
// and returns ack/read data to the granted port.
// Optional watchdog on the controller ack: define SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sdram_port_arbiter_if.slave  io_bus
);
    logic [1:0]        r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_ctrl_advn;
    logic              r_ctrl_rwn;
    logic [ADDR_W-1:0] r_ctrl_addr;
    logic [DATA_W-1:0] r_ctrl_wdata;
    logic              r_p0_ack;
    logic              r_p1_ack;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic [1:0]        w_req;
    logic              w_any;
    logic              w_grant;
    logic              w_timeout;

    // A port whose ack is on the bus this cycle is not re-served until the next cycle,
    // so a waiting peer always gets its turn.
    assign w_req = {io_bus.i_p1_req & ~r_p1_ack, io_bus.i_p0_req & ~r_p0_ack};

    rr_arb2 u_rr_arb2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_any),
        .o_grant      (w_grant)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_p0_err;
    logic             r_p1_err;

    assign w_timeout = (r_wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts clocks spent in WAIT_ACK, cleared whenever elsewhere
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd_cnt <= '0;
        end else if (r_state != ST_WAIT_ACK) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Error pulse accompanies the ack when the watchdog expires first
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p0_err <= 1'b0;
            r_p1_err <= 1'b0;
        end else begin
            r_p0_err <= io_bus.i_ctrl_init_done && (r_state == ST_WAIT_ACK) &&
                        !io_bus.i_ctrl_ack && w_timeout && !r_grant;
            r_p1_err <= io_bus.i_ctrl_init_done && (r_state == ST_WAIT_ACK) &&
                        !io_bus.i_ctrl_ack && w_timeout && r_grant;
        end
    end

    assign io_bus.o_p0_err = r_p0_err;
    assign io_bus.o_p1_err = r_p1_err;
`else
    assign w_timeout       = 1'b0;
    assign io_bus.o_p0_err = 1'b0;
    assign io_bus.o_p1_err = 1'b0;
`endif

    // Main sequencer: init hold, arbitration, strobe issue and completion routing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_WAIT_INIT;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_ctrl_advn  <= 1'b1;
            r_ctrl_rwn   <= 1'b1;
            r_ctrl_addr  <= '0;
            r_ctrl_wdata <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            r_ctrl_advn <= 1'b1;
            r_p0_ack    <= 1'b0;
            r_p1_ack    <= 1'b0;
            if (!io_bus.i_ctrl_init_done) begin
                // Controller lost init: anything in flight is abandoned silently
                r_state <= ST_WAIT_INIT;
            end else begin
                case (r_state)
                    ST_WAIT_INIT: r_state <= ST_IDLE;
                    ST_IDLE: begin
                        if (w_any) begin
                            r_grant      <= w_grant;
                            r_last_grant <= w_grant;
                            r_ctrl_rwn   <= w_grant ? io_bus.i_p1_rwn   : io_bus.i_p0_rwn;
                            r_ctrl_addr  <= w_grant ? io_bus.i_p1_addr  : io_bus.i_p0_addr;
                            r_ctrl_wdata <= w_grant ? io_bus.i_p1_wdata : io_bus.i_p0_wdata;
                            r_state      <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ISSUE: begin
                        if (!io_bus.i_ctrl_busy) begin
                            r_ctrl_advn <= 1'b0;
                            r_state     <= ST_WAIT_ACK;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (io_bus.i_ctrl_ack) begin
                            if (r_ctrl_rwn) begin
                                if (r_grant) begin
                                    r_p1_rdata <= io_bus.i_ctrl_rdata;
                                end else begin
                                    r_p0_rdata <= io_bus.i_ctrl_rdata;
                                end
                            end
                            r_p0_ack <= ~r_grant;
                            r_p1_ack <= r_grant;
                            r_state  <= ST_IDLE;
                        end else if (w_timeout) begin
                            r_p0_ack <= ~r_grant;
                            r_p1_ack <= r_grant;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_ACK;
                        end
                    end
                    default: r_state <= ST_WAIT_INIT;
                endcase
            end
        end
    end

    assign io_bus.o_ctrl_advn  = r_ctrl_advn;
    assign io_bus.o_ctrl_rwn   = r_ctrl_rwn;
    assign io_bus.o_ctrl_addr  = r_ctrl_addr;
    assign io_bus.o_ctrl_wdata = r_ctrl_wdata;
    assign io_bus.o_p0_ack     = r_p0_ack;
    assign io_bus.o_p1_ack     = r_p1_ack;
    assign io_bus.o_p0_rdata   = r_p0_rdata;
    assign io_bus.o_p1_rdata   = r_p1_rdata;
    assign io_bus.o_busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: table of single transactions plus
// hand-written sequences for init hold, contention, stalls, drops and reset.
module tb_sdram_port_arbiter;

    logic clk;
    logic rst;

    sdram_port_arbiter_if #(.ADDR_W(27), .DATA_W(32)) bus ();

    sdram_port_arbiter #(.ADDR_W(27), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int advn_cnt = 0;
    int p0_ack_cnt = 0;
    int p1_ack_cnt = 0;

    // Event counters sampled on the inactive edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_ctrl_advn === 1'b0) advn_cnt++;
            if (bus.o_p0_ack === 1'b1) p0_ack_cnt++;
            if (bus.o_p1_ack === 1'b1) p1_ack_cnt++;
        end
    end

    typedef struct {
        bit          port;
        bit          rwn;
        logic [26:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] crdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit port, input bit req, input bit rwn,
                           input logic [26:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.i_p1_req = req; bus.i_p1_rwn = rwn; bus.i_p1_addr = addr; bus.i_p1_wdata = wdata;
        end else begin
            bus.i_p0_req = req; bus.i_p0_rwn = rwn; bus.i_p0_addr = addr; bus.i_p0_wdata = wdata;
        end
    endtask

    function automatic logic port_ack(input bit port);
        return port ? bus.o_p1_ack : bus.o_p0_ack;
    endfunction

    function automatic logic [31:0] port_rdata(input bit port);
        return port ? bus.o_p1_rdata : bus.o_p0_rdata;
    endfunction

    // Steps until the advance strobe is seen low; an expired bound is a failure
    task automatic wait_advn(output int lat);
        lat = 0;
        while (bus.o_ctrl_advn !== 1'b0 && lat < 200) begin
            step();
            lat++;
        end
        if (bus.o_ctrl_advn !== 1'b0) check("advn_wait_bound", 64'd0, 64'd1);
    endtask

    // Drive one controller ack after dly cycles, returning rdata
    task automatic ctrl_ack(input int dly, input logic [31:0] rd);
        repeat (dly) step();
        bus.i_ctrl_ack = 1'b1;
        bus.i_ctrl_rdata = rd;
        step();
        bus.i_ctrl_ack = 1'b0;
        bus.i_ctrl_rdata = 32'h0BAD0BAD;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int a0, k0, k1;
        a0 = advn_cnt; k0 = p0_ack_cnt; k1 = p1_ack_cnt;
        set_req(v.port, 1'b1, v.rwn, v.addr, v.wdata);
        wait_advn(lat);
        // grant edge, then strobe edge
        check("vec_latency", 64'(lat), 64'd2);
        check("vec_ctrl_rwn", 64'(bus.o_ctrl_rwn), 64'(v.rwn));
        check("vec_ctrl_addr", 64'(bus.o_ctrl_addr), 64'(v.addr));
        check("vec_ctrl_wdata", 64'(bus.o_ctrl_wdata), 64'(v.wdata));
        ctrl_ack(v.delay, v.crdata);
        check("vec_ack", 64'(port_ack(v.port)), 64'd1);
        check("vec_rdata", 64'(port_rdata(v.port)), 64'(v.exp_rdata));
        check("vec_busy_ack", 64'(bus.o_busy), 64'd0);
        set_req(v.port, 1'b0, v.rwn, v.addr, v.wdata);
        step();
        check("vec_ack_pulse", 64'(port_ack(v.port)), 64'd0);
        check("vec_rdata_held", 64'(port_rdata(v.port)), 64'(v.exp_rdata));
        check("vec_advn_count", 64'(advn_cnt - a0), 64'd1);
        check("vec_p0_acks", 64'(p0_ack_cnt - k0), v.port ? 64'd0 : 64'd1);
        check("vec_p1_acks", 64'(p1_ack_cnt - k1), v.port ? 64'd1 : 64'd0);
    endtask

    initial begin
        int lat, a0, k0, k1, n;
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};

        vecs[0] = '{1'b0, 1'b0, 27'h0000010, 32'h00000055, 2, 32'h12345678, 32'hCAFEF00D};
        vecs[1] = '{1'b1, 1'b1, 27'h00ABCDE, 32'h00000000, 3, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 27'h7FFFFFF, 32'h00000000, 0, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[3] = '{1'b1, 1'b0, 27'h0000000, 32'hFFFFFFFF, 1, 32'h55555555, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b1, 27'h1234567, 32'h00000000, 5, 32'h0F0F0F0F, 32'h0F0F0F0F};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 27'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 27'd0, 32'd0);
        bus.i_ctrl_init_done = 1'b0;
        bus.i_ctrl_busy = 1'b0;
        bus.i_ctrl_ack = 1'b0;
        bus.i_ctrl_rdata = 32'd0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset values
        check("rst_advn", 64'(bus.o_ctrl_advn), 64'd1);
        check("rst_rwn", 64'(bus.o_ctrl_rwn), 64'd1);
        check("rst_addr", 64'(bus.o_ctrl_addr), 64'd0);
        check("rst_wdata", 64'(bus.o_ctrl_wdata), 64'd0);
        check("rst_busy", 64'(bus.o_busy), 64'd1);
        check("rst_acks", 64'({bus.o_p0_ack, bus.o_p1_ack, bus.o_p0_err, bus.o_p1_err}), 64'd0);
        check("rst_rdata", 64'({bus.o_p0_rdata, bus.o_p1_rdata}), 64'd0);

        // Init hold: request ignored until the controller is ready
        set_req(1'b0, 1'b1, 1'b1, 27'h0000020, 32'd0);
        repeat (50) step();
        check("init_no_advn", 64'(advn_cnt), 64'd0);
        check("init_no_ack", 64'(p0_ack_cnt), 64'd0);
        check("init_busy", 64'(bus.o_busy), 64'd1);
        bus.i_ctrl_init_done = 1'b1;
        wait_advn(lat);
        // leave WAIT_INIT, grant, strobe
        check("init_latency", 64'(lat), 64'd3);
        check("init_addr", 64'(bus.o_ctrl_addr), 64'h20);
        ctrl_ack(1, 32'hCAFEF00D);
        check("init_ack", 64'(bus.o_p0_ack), 64'd1);
        check("init_rdata", 64'(bus.o_p0_rdata), 64'hCAFEF00D);
        set_req(1'b0, 1'b0, 1'b1, 27'h0000020, 32'd0);
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Contention: both ports hold requests for four transactions
        a0 = advn_cnt; k0 = p0_ack_cnt; k1 = p1_ack_cnt;
        set_req(1'b0, 1'b1, 1'b0, 27'h0000100, 32'h00000011);
        set_req(1'b1, 1'b1, 1'b1, 27'h0000200, 32'h00000022);
        for (int i = 0; i < 4; i++) begin
            wait_advn(lat);
            check("cont_grant", 64'(bus.o_ctrl_addr == 27'h0000200), 64'(exp_order[i]));
            ctrl_ack(1, 32'h00003000 + 32'(i));
            check("cont_ack", 64'(port_ack(exp_order[i][0])), 64'd1);
            if (i == 3) begin
                set_req(1'b0, 1'b0, 1'b0, 27'h0000100, 32'h00000011);
                set_req(1'b1, 1'b0, 1'b1, 27'h0000200, 32'h00000022);
            end
        end
        repeat (4) step();
        check("cont_advn_count", 64'(advn_cnt - a0), 64'd4);
        check("cont_p0_acks", 64'(p0_ack_cnt - k0), 64'd2);
        check("cont_p1_acks", 64'(p1_ack_cnt - k1), 64'd2);
        check("cont_p1_rdata", 64'(bus.o_p1_rdata), 64'h00003003);

        // Busy stall in ISSUE
        a0 = advn_cnt;
        bus.i_ctrl_busy = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 27'h0000040, 32'h00000077);
        repeat (12) step();
        check("stall_no_advn", 64'(advn_cnt - a0), 64'd0);
        check("stall_busy_out", 64'(bus.o_busy), 64'd1);
        bus.i_ctrl_busy = 1'b0;
        wait_advn(lat);
        check("stall_latency", 64'(lat), 64'd1);
        ctrl_ack(0, 32'd0);
        check("stall_ack", 64'(bus.o_p0_ack), 64'd1);
        set_req(1'b0, 1'b0, 1'b0, 27'h0000040, 32'h00000077);
        repeat (3) step();
        check("stall_advn_count", 64'(advn_cnt - a0), 64'd1);

        // Init loss mid-transaction: dropped without ack
        a0 = advn_cnt; k1 = p1_ack_cnt;
        set_req(1'b1, 1'b1, 1'b1, 27'h0000080, 32'd0);
        wait_advn(lat);
        bus.i_ctrl_init_done = 1'b0;
        repeat (2) step();
        bus.i_ctrl_init_done = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 27'h0000080, 32'd0);
        repeat (10) step();
        check("initdrop_no_ack", 64'(p1_ack_cnt - k1), 64'd0);
        check("initdrop_advn", 64'(advn_cnt - a0), 64'd1);
        check("initdrop_idle", 64'(bus.o_busy), 64'd0);

        // Asynchronous reset mid-transaction
        k0 = p0_ack_cnt;
        set_req(1'b0, 1'b1, 1'b1, 27'h0000099, 32'd0);
        wait_advn(lat);
        #2 rst = 1'b1;
        #1;
        check("arst_advn", 64'(bus.o_ctrl_advn), 64'd1);
        check("arst_addr", 64'(bus.o_ctrl_addr), 64'd0);
        check("arst_rwn", 64'(bus.o_ctrl_rwn), 64'd1);
        check("arst_busy", 64'(bus.o_busy), 64'd1);
        set_req(1'b0, 1'b0, 1'b1, 27'h0000099, 32'd0);
        step();
        rst = 1'b0;
        repeat (5) step();
        check("arst_no_ack", 64'(p0_ack_cnt - k0), 64'd0);
        check("arst_rdata", 64'(bus.o_p0_rdata), 64'd0);

        // No controller ack: watchdog or indefinite wait
        set_req(1'b0, 1'b1, 1'b1, 27'h0000033, 32'd0);
        wait_advn(lat);
`ifdef SDRAM_ARB_TIMEOUT_EN
        n = 0;
        while (bus.o_p0_ack !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("wd_cycles", 64'(n), 64'd16);
        check("wd_err", 64'(bus.o_p0_err), 64'd1);
        check("wd_rdata", 64'(bus.o_p0_rdata), 64'd0);
        set_req(1'b0, 1'b0, 1'b1, 27'h0000033, 32'd0);
        step();
        check("wd_err_pulse", 64'(bus.o_p0_err), 64'd0);
`else
        k0 = p0_ack_cnt;
        repeat (40) step();
        check("nowd_no_ack", 64'(p0_ack_cnt - k0), 64'd0);
        check("nowd_busy", 64'(bus.o_busy), 64'd1);
        n = 0;
        ctrl_ack(0, 32'h600DF00D);
        check("nowd_ack", 64'(bus.o_p0_ack), 64'd1);
        check("nowd_err", 64'(bus.o_p0_err), 64'd0);
        check("nowd_rdata", 64'(bus.o_p0_rdata), 64'h600DF00D);
        set_req(1'b0, 1'b0, 1'b1, 27'h0000033, 32'd0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
